// File: rtl/crater_arbiter.sv
// crater_arbiter: N-channel terrain-damage engine.
// Bomb channels are arbitrated round-robin into a small pending-explosion
// FIFO. Each queued crater is then carved column by column into the terrain
// column memory with a read-modify-write sequence (READ, CAPT, WRITE). The
// write is issued only while the terrain write window is open.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   exp_valid/exp_ready   per-channel explosion handshake
//   exp_x/exp_y/exp_r     packed per-channel crater centre and radius
//   write_window          terrain write port free this cycle
//   rd_addr/rd_data       terrain column read (data one cycle after address)
//   wr_en/wr_addr/wr_data terrain column write
//   done                  per-channel one-cycle crater-complete pulse
//   busy                  FIFO non-empty or carve in progress
module crater_arbiter #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned COL_BITS   = 512,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned R_W        = 6,
  parameter int unsigned MAX_RADIUS = 31,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       exp_valid,
  input  logic [N_CH*X_W-1:0]   exp_x,
  input  logic [N_CH*Y_W-1:0]   exp_y,
  input  logic [N_CH*R_W-1:0]   exp_r,
  output logic [N_CH-1:0]       exp_ready,
  input  logic                  write_window,
  output logic [X_W-1:0]        rd_addr,
  input  logic [COL_BITS-1:0]   rd_data,
  output logic                  wr_en,
  output logic [X_W-1:0]        wr_addr,
  output logic [COL_BITS-1:0]   wr_data,
  output logic [N_CH-1:0]       done,
  output logic                  busy
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned XW2   = ((X_W > R_W) ? X_W : R_W) + 1;
  localparam int unsigned YW2   = ((Y_W > R_W) ? Y_W : R_W) + 1;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [R_W-1:0]  r;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_CAPT, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t              fifo_q [FIFO_DEPTH];
  entry_t              fifo_d [FIFO_DEPTH];
  entry_t              cur_q, cur_d;
  logic [X_W-1:0]      col_q, col_d, col_end_q, col_end_d;
  logic [COL_BITS-1:0] data_q, data_d;
  logic [N_CH-1:0]     done_q, done_d;

  logic                fifo_empty, fifo_full;
  logic                grant_found, push;
  logic [CH_W-1:0]     grant_ch;
  int unsigned         idx;
  entry_t              push_entry, head;
  logic [R_W-1:0]      r_in;
  logic signed [XW2-1:0] lo_x;
  logic [XW2-1:0]      hi_x;
  logic [X_W-1:0]      col_start, col_stop, dx;
  logic [R_W-1:0]      half;
  logic signed [YW2-1:0] lo_y;
  logic [YW2-1:0]      hi_y;
  int unsigned         lo_i, hi_i;
  logic [COL_BITS-1:0] mask;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign head       = fifo_q[rptr_q[PTR_W-1:0]];

  // Rotating-priority search starting at the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_found && exp_valid[idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = idx[CH_W-1:0];
      end
    end
  end

  // Ready uses the pre-pop full flag; reset forces it low asynchronously.
  always_comb begin
    push      = reset_n && grant_found && !fifo_full;
    exp_ready = '0;
    if (push) exp_ready[grant_ch] = 1'b1;
    r_in          = exp_r[grant_ch*R_W +: R_W];
    push_entry.ch = grant_ch;
    push_entry.x  = exp_x[grant_ch*X_W +: X_W];
    push_entry.y  = exp_y[grant_ch*Y_W +: Y_W];
    push_entry.r  = (r_in > R_W'(MAX_RADIUS)) ? R_W'(MAX_RADIUS) : r_in;
  end

  // Column span of the head entry, clamped to the valid column range.
  always_comb begin
    lo_x      = $signed(XW2'(head.x)) - $signed(XW2'(head.r));
    hi_x      = XW2'(head.x) + XW2'(head.r);
    col_start = lo_x[XW2-1] ? '0 : X_W'(lo_x);
    col_stop  = (hi_x > XW2'(X_MAX)) ? X_W'(X_MAX) : X_W'(hi_x);
  end

  // Vertical clear span for the current column; lo past the top row
  // shifts the low mask to zero, leaving an empty (write-through) mask.
  always_comb begin
    dx   = (col_q >= cur_q.x) ? (col_q - cur_q.x) : (cur_q.x - col_q);
    half = cur_q.r - R_W'(dx);
    lo_y = $signed(YW2'(cur_q.y)) - $signed(YW2'(half));
    hi_y = YW2'(cur_q.y) + YW2'(half);
    lo_i = lo_y[YW2-1] ? 0 : 32'(unsigned'(lo_y));
    hi_i = 32'(hi_y);
    if (hi_i > COL_BITS - 1) hi_i = COL_BITS - 1;
    mask = ({COL_BITS{1'b1}} << lo_i) & ({COL_BITS{1'b1}} >> (COL_BITS - 1 - hi_i));
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fifo_d    = fifo_q;
    cur_d     = cur_q;
    col_d     = col_q;
    col_end_d = col_end_q;
    data_d    = data_q;
    done_d    = '0;

    if (push) begin
      fifo_d[wptr_q[PTR_W-1:0]] = push_entry;
      wptr_d = wptr_q + 1'b1;
      if (32'(grant_ch) + 1 >= N_CH) rr_ptr_d = '0;
      else                           rr_ptr_d = grant_ch + 1'b1;
    end

    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        rptr_d    = rptr_q + 1'b1;
        cur_d     = head;
        col_d     = col_start;
        col_end_d = col_stop;
        state_d   = S_READ;
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT: begin
        data_d  = rd_data & ~mask;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (write_window) begin
          if (col_q == col_end_q) begin
            done_d[cur_q.ch] = 1'b1;
            state_d          = S_DONE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fifo_q    <= '{default: '0};
      cur_q     <= '0;
      col_q     <= '0;
      col_end_q <= '0;
      data_q    <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fifo_q    <= fifo_d;
      cur_q     <= cur_d;
      col_q     <= col_d;
      col_end_q <= col_end_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // The write strobe is combinational so it can only appear inside WRITE.
  assign wr_en   = (state_q == S_WRITE) && write_window;
  assign wr_addr = col_q;
  assign rd_addr = col_q;
  assign wr_data = data_q;
  assign done    = done_q;
  assign busy    = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_crater_arbiter.sv
// tb_crater_arbiter: scoreboard bench for crater_arbiter.
// Stimulus pushes expected column writes and done pulses into queues; a
// negedge monitor pops and compares whenever the DUT writes or signals done.
// The terrain is a read-only pattern ROM with one cycle of read latency.
module tb_crater_arbiter;

  logic         clk;
  logic         reset_n;
  logic [1:0]   exp_valid;
  logic [19:0]  exp_x;
  logic [19:0]  exp_y;
  logic [11:0]  exp_r;
  logic [1:0]   exp_ready;
  logic         write_window;
  logic [9:0]   rd_addr;
  logic [511:0] rd_data;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [511:0] wr_data;
  logic [1:0]   done;
  logic         busy;

  crater_arbiter #(
    .N_CH(2), .COL_BITS(512), .X_W(10), .Y_W(10), .R_W(6),
    .MAX_RADIUS(31), .X_MAX(639), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .exp_valid(exp_valid), .exp_x(exp_x), .exp_y(exp_y), .exp_r(exp_r),
    .exp_ready(exp_ready), .write_window(write_window),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .busy(busy)
  );

  typedef struct { int addr; logic [511:0] data; } wexp_t;
  typedef struct { int ch; int cyc; } dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [511:0] base_col(input int c);
    logic [511:0] v;
    v = '1;
    if (c % 2 == 1) v[500] = 1'b0;
    if (c % 3 == 0) v[3] = 1'b0;
    return v;
  endfunction

  // Terrain ROM: address sampled mid-cycle, data presented next cycle.
  initial begin
    int a;
    rd_data = '0;
    forever begin
      @(negedge clk);
      a = int'(rd_addr);
      @(posedge clk);
      #1 rd_data = base_col(a);
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_col(input int c, input int lo, input int hi);
    wexp_t e;
    e.addr = c;
    e.data = base_col(c);
    for (int b = lo; b <= hi; b++) e.data[b] = 1'b0;
    wq.push_back(e);
  endtask

  task automatic push_done(input int ch, input int dcyc);
    dexp_t d;
    d.ch  = ch;
    d.cyc = dcyc;
    dq.push_back(d);
  endtask

  // Reference crater model in plain integer arithmetic; dcyc=0 skips timing.
  task automatic expect_crater(input int ch, input int x, input int y, input int r, input int dcyc);
    int rc, cs, ce, d, half, lo, hi;
    rc = (r > 31) ? 31 : r;
    cs = x - rc; if (cs < 0) cs = 0;
    ce = x + rc; if (ce > 639) ce = 639;
    for (int c = cs; c <= ce; c++) begin
      d = c - x; if (d < 0) d = -d;
      half = rc - d;
      lo = y - half; if (lo < 0) lo = 0;
      hi = y + half; if (hi > 511) hi = 511;
      push_col(c, lo, hi);
    end
    push_done(ch, dcyc);
  endtask

  // Monitor: every write or done pulse is matched against the queues.
  initial forever begin
    wexp_t we;
    dexp_t de;
    @(negedge clk);
    if (wr_en) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr);
      end else begin
        we = wq.pop_front();
        chk("wr_addr", 512'(wr_addr), 512'(we.addr));
        chk("wr_data", wr_data, we.data);
      end
    end
    if (done != 2'b00) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got %b expected no pulse", done);
      end else begin
        de = dq.pop_front();
        chk("done_onehot", 512'(done), 512'(1) << de.ch);
        if (de.cyc != 0) chk("done_cycle", 512'(cyc), 512'(de.cyc));
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1);
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic submit(input int ch, input int x, input int y, input int r,
                        output int acc, output int waited);
    exp_x[ch*10 +: 10] = x[9:0];
    exp_y[ch*10 +: 10] = y[9:0];
    exp_r[ch*6 +: 6]   = r[5:0];
    exp_valid[ch]      = 1'b1;
    acc    = -1;
    waited = 0;
    while (waited < 400) begin
      @(negedge clk);
      if (exp_ready[ch]) begin
        @(posedge clk);
        #1 acc = cyc;
        break;
      end
      waited++;
    end
    exp_valid[ch] = 1'b0;
    chk("accept_in_budget", 512'(acc >= 0), 512'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_in_budget", 512'(n < budget), 512'(1));
  endtask

  initial begin
    int a, b, w;
    logic [511:0] expv;

    reset_n = 1'b0;
    exp_valid = 2'b11;
    exp_x = '0; exp_y = '0; exp_r = '0;
    write_window = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exp_ready", 512'(exp_ready), '0);
    chk("rst_wr_en",     512'(wr_en),     '0);
    chk("rst_wr_addr",   512'(wr_addr),   '0);
    chk("rst_wr_data",   wr_data,         '0);
    chk("rst_rd_addr",   512'(rd_addr),   '0);
    chk("rst_done",      512'(done),      '0);
    chk("rst_busy",      512'(busy),      '0);
    exp_valid = 2'b00;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single interior crater, hand-computed column spans.
    submit(0, 100, 200, 2, a, w);
    push_col(98, 200, 200);
    push_col(99, 199, 201);
    push_col(100, 198, 202);
    push_col(101, 199, 201);
    push_col(102, 200, 200);
    push_done(0, a + 17);
    wait_idle(100);

    // Edge clamps: left edge, right/top edge, bottom row, empty mask, radius clamp.
    submit(0, 1, 5, 3, a, w);     expect_crater(0, 1, 5, 3, a + 17);     wait_idle(100);
    submit(1, 638, 510, 3, a, w); expect_crater(1, 638, 510, 3, a + 17); wait_idle(100);
    submit(0, 300, 1, 2, a, w);   expect_crater(0, 300, 1, 2, a + 17);   wait_idle(100);
    submit(0, 500, 600, 2, a, w); expect_crater(0, 500, 600, 2, a + 17); wait_idle(100);
    submit(0, 320, 256, 63, a, w); expect_crater(0, 320, 256, 63, a + 191); wait_idle(400);

    // Simultaneous requests from pointer 0.
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_x = {10'd210, 10'd200};
    exp_y = {10'd100, 10'd100};
    exp_r = {6'd1, 6'd1};
    exp_valid = 2'b11;
    @(negedge clk);
    chk("rr_first_ready", 512'(exp_ready), 512'(2'b01));
    @(posedge clk); #1 a = cyc;
    expect_crater(0, 200, 100, 1, a + 11);
    @(negedge clk);
    chk("rr_second_ready", 512'(exp_ready), 512'(2'b10));
    @(posedge clk); #1 exp_valid = 2'b00;
    expect_crater(1, 210, 100, 1, a + 23);
    wait_idle(100);

    // Write-window stall at the first WRITE.
    write_window = 1'b0;
    submit(0, 50, 60, 0, a, w);
    push_col(50, 60, 60);
    expv = base_col(50);
    expv[60] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_wr_en", 512'(wr_en), '0);
      chk("stall_wr_data", wr_data, expv);
      @(posedge clk); #1;
    end
    push_done(0, cyc + 1);
    write_window = 1'b1;
    wait_idle(50);

    // Backpressure: carve engine stalled, FIFO fills to four.
    write_window = 1'b0;
    submit(0, 20, 30, 0, a, w);
    expect_crater(0, 20, 30, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      submit(0, 40 + 2 * i, 30, 0, a, w);
      chk("bp_accept_wait", 512'(w), '0);
      expect_crater(0, 40 + 2 * i, 30, 0, 0);
    end
    exp_x[9:0] = 10'd48; exp_y[9:0] = 10'd30; exp_r[5:0] = 6'd0;
    exp_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_ready", 512'(exp_ready), '0);
    end
    chk("bp_busy", 512'(busy), 512'(1));
    @(posedge clk); #1 write_window = 1'b1;
    submit(0, 48, 30, 0, a, w);
    expect_crater(0, 48, 30, 0, 0);
    wait_idle(200);

    // Reset during the third column of a 7-column crater with one queued.
    submit(0, 400, 100, 3, a, w);
    push_col(397, 100, 100);
    push_col(398, 99, 101);
    submit(1, 100, 50, 0, b, w);
    while (cyc < a + 9) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",   512'(wr_en),   '0);
    chk("mid_rst_busy",    512'(busy),    '0);
    chk("mid_rst_done",    512'(done),    '0);
    chk("mid_rst_wr_addr", 512'(wr_addr), '0);
    chk("mid_rst_wr_data", wr_data,       '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy",   512'(busy),      '0);
    chk("post_rst_wq",     512'(wq.size()), '0);
    chk("post_rst_dq",     512'(dq.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
